// File: rtl/shift_seq8.sv
// Sequential 8-bit shifter: iterates a one-bit shift stage amount times; done at start+amount+1 cycles.
// No backpressure: start is accepted only in IDLE/DONE and silently ignored while busy.

module shift1_8 (
    input  logic [7:0] d,
    input  logic       rl,
    output logic [7:0] q,
    output logic       co
);
    assign q  = rl ? {d[6:0], 1'b0} : {1'b0, d[7:1]};
    assign co = rl ? d[7] : d[0];
endmodule

module shift_seq8 #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    input  logic [CNT_W-1:0] amount,
    input  logic             dir,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout,
    output logic             carry_out
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             dir_r;
    logic [WIDTH-1:0] stage_q;
    logic             stage_co;

    shift1_8 u_stage (
        .d  (dout),
        .rl (dir_r),
        .q  (stage_q),
        .co (stage_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            dout      <= '0;
            carry_out <= 1'b0;
            cnt       <= '0;
            dir_r     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    // DONE accepts a new start so back-to-back operations need no bubble
                    if (start) begin
                        dout      <= din;
                        cnt       <= amount;
                        dir_r     <= dir;
                        carry_out <= 1'b0;
                        state     <= (amount != '0) ? SHIFT : DONE;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    dout      <= stage_q;
                    carry_out <= stage_co;
                    cnt       <= cnt - 1'b1;
                    if (cnt == CNT_W'(1))
                        state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);
endmodule
